// File: rtl/scalar_pkg.sv
// -----------------------------------------------------------------------------
// scalar_pkg
// Shared constants and types for the scalar write-back arbiter.
//   REG_ADDR_W      : register-file index width (5 -> 32 registers, R0 hardwired)
//   DEFAULT_DATA_W  : default write-back data / counter width
//   DEFAULT_NREQ    : default number of write-back requesters
//   req_idx_e       : requester indices (ALU, MEM, VEC)
// -----------------------------------------------------------------------------
package scalar_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int DEFAULT_DATA_W = 19;
  localparam int DEFAULT_NREQ   = 3;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MEM = 2'd1,
    REQ_VEC = 2'd2
  } req_idx_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin grant generator with a registered priority pointer.
// The grant is the first valid requester at or after the pointer (wrapping),
// and the pointer moves to one past the granted index. No grant while hold.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (pointer -> 0)
//   hold  : freeze; forces grant to zero and therefore freezes the pointer
//   valid : per-requester request
//   grant : one-hot or zero grant, combinational from valid/hold/pointer
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [NREQ-1:0]  upper_mask;
  logic [NREQ-1:0]  masked;
  logic [NREQ-1:0]  pick_src;

  // upper_mask selects requesters whose index is at or above the pointer.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign upper_mask[gi] = (PTR_W'(gi) >= ptr_reg);
    end
  endgenerate

  // Search the upper window first; if it is empty, wrap and search from 0.
  // Isolating the lowest set bit of the chosen window gives the one-hot grant.
  always_comb begin
    masked   = valid & upper_mask;
    pick_src = (|masked) ? masked : valid;
    grant    = '0;
    if (!hold) begin
      grant = pick_src & (~pick_src + NREQ'(1));
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        ptr_next = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// -----------------------------------------------------------------------------
// scalar_wb_arbiter
// Round-robin arbitration of NREQ write-back requesters onto one register-file
// write port. The granted transfer appears on rf_* one cycle after the
// handshake. Writes to R0 are accepted but never enabled.
// Optional feature macro: WB_CONFLICT_CNT_EN adds the conflict_count port.
// Ports:
//   clk, rst       : clock; asynchronous active-high reset
//   hold           : pipeline freeze (no grants, counters still run)
//   req_valid      : [NREQ] request per requester (0=ALU, 1=MEM, 2=VEC)
//   req_rd         : [NREQ*5] destination index, requester i at bits [i*5 +: 5]
//   req_wd         : [NREQ*DATA_W] write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready      : [NREQ] one-hot grant
//   rf_wes/rf_rd/rf_wd : registered register-file write port
//   stall_count    : saturating count of cycles with an ungranted valid request
//   conflict_count : saturating count of cycles with >=2 valid requests (macro)
// -----------------------------------------------------------------------------
module scalar_wb_arbiter
  import scalar_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NREQ   = DEFAULT_NREQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NREQ*DATA_W-1:0]     req_wd,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rf_wes,
  output logic [REG_ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]          rf_wd,
  output logic [DATA_W-1:0]          stall_count
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [DATA_W-1:0]          conflict_count
`endif
);

  logic [NREQ-1:0]       grant;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] rd_masked [NREQ];
  logic [DATA_W-1:0]     wd_masked [NREQ];
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0]     sel_wd;

  logic                  rf_wes_reg;
  logic                  rf_wes_next;
  logic [REG_ADDR_W-1:0] rf_rd_reg;
  logic [REG_ADDR_W-1:0] rf_rd_next;
  logic [DATA_W-1:0]     rf_wd_reg;
  logic [DATA_W-1:0]     rf_wd_next;
  logic                  stall_event;
  logic [DATA_W-1:0]     stall_count_reg;
  logic [DATA_W-1:0]     stall_count_next;

  wb_rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .valid(req_valid),
    .grant(grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Grant is one-hot, so an AND-OR mux selects the winner's rd/wd.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
      assign rd_masked[gi] = req_rd[gi*REG_ADDR_W +: REG_ADDR_W] & {REG_ADDR_W{grant[gi]}};
      assign wd_masked[gi] = req_wd[gi*DATA_W +: DATA_W] & {DATA_W{grant[gi]}};
    end
  endgenerate

  always_comb begin
    sel_rd = '0;
    sel_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_rd = sel_rd | rd_masked[i];
      sel_wd = sel_wd | wd_masked[i];
    end
  end

  // A stall cycle is any cycle where some valid requester is left without a
  // grant; this naturally covers hold cycles, where the grant is forced to 0.
  assign stall_event = |(req_valid & ~grant);

  always_comb begin
    rf_wes_next      = 1'b0;
    rf_rd_next       = rf_rd_reg;
    rf_wd_next       = rf_wd_reg;
    stall_count_next = stall_count_reg;
    if (xfer) begin
      // R0 transfers complete the handshake but never raise the write enable.
      rf_wes_next = (sel_rd != '0);
      rf_rd_next  = sel_rd;
      rf_wd_next  = sel_wd;
    end
    if (stall_event && (stall_count_reg != {DATA_W{1'b1}})) begin
      stall_count_next = stall_count_reg + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wes_reg      <= 1'b0;
      rf_rd_reg       <= '0;
      rf_wd_reg       <= '0;
      stall_count_reg <= '0;
    end else begin
      rf_wes_reg      <= rf_wes_next;
      rf_rd_reg       <= rf_rd_next;
      rf_wd_reg       <= rf_wd_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign rf_wes      = rf_wes_reg;
  assign rf_rd       = rf_rd_reg;
  assign rf_wd       = rf_wd_reg;
  assign stall_count = stall_count_reg;

`ifdef WB_CONFLICT_CNT_EN
  logic              conflict_event;
  logic [DATA_W-1:0] conflict_count_reg;
  logic [DATA_W-1:0] conflict_count_next;

  // x & (x-1) is non-zero exactly when two or more bits of x are set.
  assign conflict_event = |(req_valid & (req_valid - NREQ'(1)));

  always_comb begin
    conflict_count_next = conflict_count_reg;
    if (conflict_event && (conflict_count_reg != {DATA_W{1'b1}})) begin
      conflict_count_next = conflict_count_reg + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_count_reg <= '0;
    end else begin
      conflict_count_reg <= conflict_count_next;
    end
  end

  assign conflict_count = conflict_count_reg;
`endif

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 19: width of write-back data and counters.
REQ-002 Parameter NREQ, default 3: number of write-back requesters; requester 0 is ALU, 1 is MEM, 2 is VEC.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hold  input  1  pipeline freeze; no grants while high.
REQ-006 req_valid  input  NREQ  per-requester write-back request.
REQ-007 req_rd  input  NREQ x 5  per-requester destination register index.
REQ-008 req_wd  input  NREQ x DATA_W  per-requester write data.
REQ-009 req_ready  output  NREQ  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-010 rf_wes  output  1  register-file write enable, registered.
REQ-011 rf_rd  output  5  register-file write index, registered.
REQ-012 rf_wd  output  DATA_W  register-file write data, registered.
REQ-013 stall_count  output  DATA_W  number of cycles in which at least one valid requester was not granted.
REQ-014 conflict_count  output  DATA_W  number of cycles with two or more valid requesters; present only with WB_CONFLICT_CNT_EN.

Function
REQ-015 req_ready SHALL be combinational from req_valid, hold and the priority pointer.
REQ-016 req_ready SHALL be one-hot or zero.
REQ-017 When hold=0, the arbiter SHALL grant the first valid requester at or after the pointer, in increasing index order with wrap from NREQ-1 to 0.
REQ-018 After each grant to index g, the pointer SHALL become (g+1) mod NREQ.
REQ-019 The pointer SHALL hold its value when there is no grant.
REQ-020 A granted transfer SHALL appear on rf_wes/rf_rd/rf_wd exactly one cycle after the handshake cycle.
REQ-021 rf_wes SHALL be high for exactly one cycle per transfer.
REQ-022 rf_wes SHALL be low in any cycle that follows a cycle with no transfer.
REQ-023 A transfer with rd=0 SHALL be accepted (ready high) but SHALL produce rf_wes=0; register 0 is never written.
REQ-024 With hold=1: req_ready SHALL be all zero, the pointer SHALL be frozen, and no new transfer is issued. A transfer accepted in the previous cycle SHALL still complete.
REQ-025 Requesters SHALL keep valid, rd and wd stable until ready; the arbiter SHALL NOT drop or reorder an accepted transfer.
REQ-026 A continuously valid requester SHALL be granted within NREQ cycles when hold=0.
REQ-027 Two requesters targeting the same rd in the same cycle SHALL be serialised in round-robin order; the later write wins in the register file.
REQ-028 stall_count SHALL increment by 1 in each cycle where any req_valid[i]=1 and req_ready[i]=0, including hold cycles.
REQ-029 stall_count SHALL saturate at 2^DATA_W-1.
REQ-030 A single valid requester with hold=0 SHALL be granted in the same cycle and SHALL NOT be counted as a stall.

Reset
REQ-031 On rst, the arbiter SHALL immediately clear: rf_wes=0, rf_rd=0, rf_wd=0, pointer=0, stall_count=0 and conflict_count=0.
REQ-032 A transfer in flight when rst asserts SHALL be discarded; rf_wes SHALL be 0 from reset assertion onward.
REQ-033 In the first cycle after rst deasserts, the arbiter SHALL grant normally starting from requester 0.

Configuration
REQ-034 When macro WB_CONFLICT_CNT_EN is defined, the port conflict_count SHALL exist.
REQ-035 When WB_CONFLICT_CNT_EN is defined, conflict_count SHALL increment in each cycle with two or more req_valid bits high, regardless of hold, and SHALL saturate at 2^DATA_W-1.
REQ-036 When WB_CONFLICT_CNT_EN is undefined, the port and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-037 Package scalar_pkg SHALL hold the following: REG_ADDR_W=5, the default DATA_W, NREQ, and the requester-index enum (REQ_ALU, REQ_MEM, REQ_VEC).
REQ-038 The design SHALL contain exactly one sub-module, wb_rr_arbiter, which holds the pointer register and the one-hot grant logic; it SHALL be parameterised by NREQ.

Verification
REQ-039 Bench scenario: reset, then ALU valid alone with rd=5, wd=0x1234 -> ready[0] high that cycle; next cycle rf_wes=1, rf_rd=5, rf_wd=0x1234; stall_count=0.
REQ-040 Bench scenario: all three valid continuously for 6 cycles -> grants in order 0,1,2,0,1,2; stall_count=6; conflict_count=6 with the macro defined.
REQ-041 Bench scenario: MEM valid with rd=0, wd=0x7 -> ready[1] high; following cycle rf_wes=0.
REQ-042 Bench scenario: ALU and VEC valid, both with rd=9; hold=1 for 2 cycles, then 0 -> no grants and stall_count=2 during hold; after hold, VEC is written to R9 and then ALU is written to R9, or the reverse, according to the pointer.
REQ-043 Bench scenario: rst pulsed during the cycle after an ALU handshake -> rf_wes stays 0 and the pointer returns to 0; the next simultaneous ALU+MEM request grants ALU first.
REQ-044 Bench scenario: force stall_count to 2^19-2 and generate 3 stall cycles -> stall_count holds at 0x7FFFF.
